// File: rtl/rx_slot_ctrl.sv
// rx_slot_ctrl: steers UDP payloads into a ring of fixed-size RX memory slots and tracks commits/releases.
// Optional RX_SLOT_DROP_CNT_EN enables the saturating drop counter; otherwise drop_cnt is tied to 0.
module rx_slot_ctrl #(
  parameter int NSLOT = 4,
  parameter int SLOT_AW = 9,
  parameter int ADDR_W = 11,
  localparam int PW = $clog2(NSLOT)
) (
  input  logic              RX_CLK,
  input  logic              rst,
  input  logic              rx_udp_data_v,
  input  logic [7:0]        rx_udp_data,
  input  logic              release_i,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_din,
  output logic              pkt_avail,
  output logic              pkt_irq,
  output logic [PW-1:0]     rd_slot,
  output logic [SLOT_AW:0]  rd_len,
  output logic [PW:0]       full_cnt,
  output logic [15:0]       drop_cnt
);
  typedef enum logic [1:0] {IDLE, WRITE, DROP} state_t;
  state_t            state_q, state_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [SLOT_AW:0]  offset_q, offset_d;
  logic [SLOT_AW:0]  len_q [NSLOT];
  logic [SLOT_AW:0]  len_d [NSLOT];
  logic [PW:0]       full_cnt_q, full_cnt_d;
  logic              wait_q, wait_d, mem_we_q, mem_we_d, pkt_irq_q, pkt_irq_d, pkt_avail_q, pkt_avail_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_din_q, mem_din_d;
  logic              commit, rel;
  // after reset, ignore the tail of any packet that was in flight
  always_comb begin
    state_d = state_q;
    wr_ptr_d = wr_ptr_q;
    offset_d = offset_q;
    len_d = len_q;
    wait_d = wait_q & rx_udp_data_v;
    mem_we_d = 1'b0;
    mem_addr_d = ADDR_W'({wr_ptr_q, offset_q[SLOT_AW-1:0]});
    mem_din_d = rx_udp_data;
    commit = 1'b0;
    case (state_q)
      IDLE: if (rx_udp_data_v && !wait_q) begin
        if (full_cnt_q == (PW+1)'(NSLOT)) state_d = DROP;
        else begin
          state_d = WRITE;
          mem_we_d = 1'b1;
          offset_d = offset_q + 1'b1;
        end
      end
      WRITE: if (rx_udp_data_v) begin
        if (offset_q[SLOT_AW]) state_d = DROP;
        else begin
          mem_we_d = 1'b1;
          offset_d = offset_q + 1'b1;
        end
      end else begin
        commit = 1'b1;
        len_d[wr_ptr_q] = offset_q;
        wr_ptr_d = wr_ptr_q + 1'b1;
        offset_d = '0;
        state_d = IDLE;
      end
      default: if (!rx_udp_data_v) begin
        offset_d = '0;
        state_d = IDLE;
      end
    endcase
    rel = release_i && full_cnt_q != '0;
    rd_ptr_d = rel ? rd_ptr_q + 1'b1 : rd_ptr_q;
    full_cnt_d = full_cnt_q + (PW+1)'(commit) - (PW+1)'(rel);
    pkt_avail_d = full_cnt_d != '0;
    pkt_irq_d = commit;
  end
  always_ff @(posedge RX_CLK) begin
    if (rst) begin
      state_q <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      offset_q <= '0;
      len_q <= '{default: '0};
      full_cnt_q <= '0;
      wait_q <= 1'b1;
      mem_we_q <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q <= '0;
      pkt_irq_q <= 1'b0;
      pkt_avail_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      offset_q <= offset_d;
      len_q <= len_d;
      full_cnt_q <= full_cnt_d;
      wait_q <= wait_d;
      mem_we_q <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q <= mem_din_d;
      pkt_irq_q <= pkt_irq_d;
      pkt_avail_q <= pkt_avail_d;
    end
  end
`ifdef RX_SLOT_DROP_CNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;
  always_comb drop_cnt_d = (state_q == DROP && !rx_udp_data_v && drop_cnt_q != 16'hFFFF) ? drop_cnt_q + 16'd1 : drop_cnt_q;
  always_ff @(posedge RX_CLK) drop_cnt_q <= rst ? '0 : drop_cnt_d;
  assign drop_cnt = drop_cnt_q;
`else
  assign drop_cnt = '0;
`endif
  assign mem_we = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_din = mem_din_q;
  assign pkt_avail = pkt_avail_q;
  assign pkt_irq = pkt_irq_q;
  assign rd_slot = rd_ptr_q;
  assign rd_len = len_q[rd_ptr_q];
  assign full_cnt = full_cnt_q;
endmodule

// File: tb/tb_rx_slot_ctrl.sv
// tb_rx_slot_ctrl: scoreboard bench for rx_slot_ctrl; expected memory writes are queued as bytes are driven.
module tb_rx_slot_ctrl;
  logic RX_CLK = 0, rst = 1, v = 0, rel = 0;
  logic [7:0] d = 0;
  logic mem_we, pkt_avail, pkt_irq;
  logic [10:0] mem_addr;
  logic [7:0] mem_din;
  logic [1:0] rd_slot;
  logic [9:0] rd_len;
  logic [2:0] full_cnt;
  logic [15:0] drop_cnt;
  int n_run = 0, n_fail = 0, n_wr = 0, n_exp_wr = 0;
`ifdef RX_SLOT_DROP_CNT_EN
  localparam int DROP1 = 1;
`else
  localparam int DROP1 = 0;
`endif
  typedef struct {logic [10:0] a; logic [7:0] d;} wr_t;
  wr_t sb[$];
  rx_slot_ctrl dut (.RX_CLK(RX_CLK), .rst(rst), .rx_udp_data_v(v), .rx_udp_data(d), .release_i(rel),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .pkt_avail(pkt_avail), .pkt_irq(pkt_irq),
    .rd_slot(rd_slot), .rd_len(rd_len), .full_cnt(full_cnt), .drop_cnt(drop_cnt));
  always #5 RX_CLK = ~RX_CLK;
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  always @(negedge RX_CLK) if (mem_we) begin
    wr_t e;
    n_wr++;
    if (sb.size() == 0) chk("we_expected", 32'(sb.size()), 1);
    else begin
      e = sb.pop_front();
      chk("wr_addr", 32'(mem_addr), 32'(e.a));
      chk("wr_data", 32'(mem_din), 32'(e.d));
    end
  end
  task automatic do_reset();
    @(negedge RX_CLK); rst = 1; v = 0; rel = 0;
    @(negedge RX_CLK); rst = 0;
  endtask
  task automatic send(int n, int base, int seed, bit exp_wr, bit rel_end = 0);
    for (int i = 0; i < n; i++) begin
      @(negedge RX_CLK); v = 1; d = 8'(seed + i);
      if (exp_wr && i < 512) begin
        sb.push_back('{11'(base + i), 8'(seed + i)});
        n_exp_wr++;
      end
    end
    @(negedge RX_CLK); v = 0; rel = rel_end;
    @(negedge RX_CLK); rel = 0;
  endtask
  task automatic pulse_rel();
    @(negedge RX_CLK); rel = 1;
    @(negedge RX_CLK); rel = 0;
  endtask
  task automatic chk_status(string tag, int irq, int avail, int slot, int len, int cnt);
    chk({tag, "_irq"}, 32'(pkt_irq), 32'(irq));
    chk({tag, "_avail"}, 32'(pkt_avail), 32'(avail));
    chk({tag, "_slot"}, 32'(rd_slot), 32'(slot));
    chk({tag, "_len"}, 32'(rd_len), 32'(len));
    chk({tag, "_cnt"}, 32'(full_cnt), 32'(cnt));
  endtask
  initial begin
    repeat (2) @(negedge RX_CLK);
    chk("rst_we", 32'(mem_we), 0);
    chk("rst_addr", 32'(mem_addr), 0);
    chk("rst_din", 32'(mem_din), 0);
    chk("rst_drop", 32'(drop_cnt), 0);
    chk_status("rst", 0, 0, 0, 0, 0);
    rst = 0;
    send(10, 0, 0, 1);
    chk_status("single", 1, 1, 0, 10, 1);
    @(negedge RX_CLK);
    chk("single_irq_pulse", 32'(pkt_irq), 0);
    do_reset();
    for (int p = 0; p < 4; p++) send(5, p * 512, 16 * p + 1, 1);
    chk_status("fill", 1, 1, 0, 5, 4);
    send(6, 0, 8'hA0, 0);
    chk_status("fill_drop", 0, 1, 0, 5, 4);
    chk("fill_drop_cnt", 32'(drop_cnt), DROP1);
    pulse_rel();
    chk_status("rel1", 0, 1, 1, 5, 3);
    send(3, 0, 8'hC0, 1);
    chk_status("wrap", 1, 1, 1, 5, 4);
    pulse_rel();
    send(2, 12'h200, 8'hD0, 1);
    chk_status("wrap2", 1, 1, 2, 5, 4);
    do_reset();
    send(513, 0, 8'h30, 1);
    chk_status("ovf", 0, 0, 0, 0, 0);
    chk("ovf_drop_cnt", 32'(drop_cnt), DROP1);
    send(4, 0, 8'h55, 1);
    chk_status("ovf_next", 1, 1, 0, 4, 1);
    send(7, 12'h200, 8'h60, 1);
    chk_status("sim_pre", 1, 1, 0, 4, 2);
    send(9, 12'h400, 8'h70, 1, 1);
    chk_status("sim", 1, 1, 1, 7, 2);
    send(1, 12'h600, 8'h80, 1);
    chk_status("sim_wr", 1, 1, 1, 7, 3);
    do_reset();
    pulse_rel();
    chk_status("rel_empty", 0, 0, 0, 0, 0);
    send(2, 0, 8'h90, 1);
    for (int i = 0; i < 20; i++) begin
      @(negedge RX_CLK);
      if (i == 4) begin
        rst = 0;
        chk("mid_we", 32'(mem_we), 0);
        chk("mid_drop", 32'(drop_cnt), 0);
        chk_status("mid", 0, 0, 0, 0, 0);
      end
      v = 1; d = 8'(8'hE0 + i);
      if (i < 3) begin
        sb.push_back('{11'(12'h200 + i), 8'(8'hE0 + i)});
        n_exp_wr++;
      end
      if (i == 3) rst = 1;
    end
    @(negedge RX_CLK); v = 0;
    send(3, 0, 8'hF0, 1);
    chk_status("post_rst", 1, 1, 0, 3, 1);
    repeat (3) @(negedge RX_CLK);
    chk("sb_empty", 32'(sb.size()), 0);
    chk("wr_count", 32'(n_wr), 32'(n_exp_wr));
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
